// File: rtl/contador_pkg.sv
// Shared constants and BCD helpers for the clock-datapath counters.
// Used by contador_bcd_modn and bcd_digit.
package contador_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam int         MOD_SEG  = 60;
    localparam int         MOD_MIN  = 60;
    localparam int         MOD_HORA = 24;

    function automatic logic [7:0] bin2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit bcd_valid(input logic [7:0] b);
        return (b[7:4] <= BCD_MAX) && (b[3:0] <= BCD_MAX);
    endfunction

    function automatic int bcd2bin(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0..9) counter with synchronous clear, load, forced wrap and up/down step.
// Priority: clear_n low > load > wrap > inc > dec.
module bcd_digit
    import contador_pkg::*;
#(
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       wrap,
    input  logic [3:0] wrap_val,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       tc
);

    logic [3:0] q_reg;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            q_reg <= RST_VAL;
        end else if (load) begin
            q_reg <= load_val;
        end else if (wrap) begin
            q_reg <= wrap_val;
        end else if (inc) begin
            q_reg <= (q_reg == BCD_MAX) ? 4'd0 : q_reg + 4'd1;
        end else if (dec) begin
            q_reg <= (q_reg == 4'd0) ? BCD_MAX : q_reg - 4'd1;
        end
    end

    // Borrow/carry into the next decade, valid in the cycle the step is requested.
    assign tc = (inc && (q_reg == BCD_MAX)) || (dec && (q_reg == 4'd0));
    assign q  = q_reg;

endmodule

// File: rtl/contador_bcd_modn.sv
// Two-digit BCD modulo-MOD counter with load check, terminal-count carry and load_err.
// Define CONTADOR_DOWN_EN to add the `down` input for decrementing.
module contador_bcd_modn
    import contador_pkg::*;
#(
    parameter int MOD       = MOD_SEG,
    parameter int RESET_VAL = 0
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       en,
`ifdef CONTADOR_DOWN_EN
    input  logic       down,
`endif
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] q_units,
    output logic [3:0] q_tens,
    output logic       carry,
    output logic       load_err
);

    localparam logic [7:0] TERM_BCD = bin2bcd(MOD - 1);
    localparam logic [7:0] RST_BCD  = bin2bcd(RESET_VAL);

    logic       dir_down;
    logic       load_ok;
    logic       load_take;
    logic       terminal;
    logic       step;
    logic       wrap_now;
    logic [1:0] inc_d;
    logic [1:0] dec_d;
    logic [1:0] tc_d;
    logic [3:0] q_d [2];
    logic       load_err_reg;

`ifdef CONTADOR_DOWN_EN
    assign dir_down = down;
`else
    assign dir_down = 1'b0;
`endif

    assign load_ok   = bcd_valid(load_val) && (bcd2bin(load_val) < MOD);
    assign load_take = load && load_ok;

    assign terminal = dir_down ? ({q_d[1], q_d[0]} == 8'h00)
                               : ({q_d[1], q_d[0]} == TERM_BCD);

    // Any load cycle, accepted or not, suppresses counting.
    assign step     = en && !load;
    assign wrap_now = step && terminal;

    assign inc_d[0] = step && !dir_down;
    assign inc_d[1] = step && !dir_down && tc_d[0];
    assign dec_d[0] = step && dir_down;
    assign dec_d[1] = step && dir_down && tc_d[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            localparam logic [3:0] WRAP_DN = TERM_BCD[gi*4 +: 4];
            bcd_digit #(
                .RST_VAL(RST_BCD[gi*4 +: 4])
            ) u_digit (
                .clk     (clk),
                .clear_n (clear_n),
                .inc     (inc_d[gi]),
                .dec     (dec_d[gi]),
                .wrap    (wrap_now),
                .wrap_val(dir_down ? WRAP_DN : 4'd0),
                .load    (load_take),
                .load_val(load_val[gi*4 +: 4]),
                .q       (q_d[gi]),
                .tc      (tc_d[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            load_err_reg <= 1'b0;
        end else begin
            load_err_reg <= load && !load_ok;
        end
    end

    assign q_units  = q_d[0];
    assign q_tens   = q_d[1];
    assign carry    = en && terminal;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_contador_bcd_modn.sv
// Randomized and directed bench for contador_bcd_modn: a MOD=60 and a MOD=24 instance
// share stimulus and are compared against an integer-arithmetic reference model.
module tb_contador_bcd_modn;

    logic       clk = 1'b0;
    logic       clear_n = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       down = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [3:0] ua, ta, ub, tb;
    logic       ca, ea, cb, eb;

    int  n_checks = 0;
    int  n_errors = 0;
    int  va = 0, vb = 12;
    bit  ea_m = 0, eb_m = 0;

    always #5 clk = ~clk;

    contador_bcd_modn #(.MOD(60), .RESET_VAL(0)) dut_a (
        .clk(clk), .clear_n(clear_n), .en(en),
`ifdef CONTADOR_DOWN_EN
        .down(down),
`endif
        .load(load), .load_val(load_val),
        .q_units(ua), .q_tens(ta), .carry(ca), .load_err(ea)
    );

    contador_bcd_modn #(.MOD(24), .RESET_VAL(12)) dut_b (
        .clk(clk), .clear_n(clear_n), .en(en),
`ifdef CONTADOR_DOWN_EN
        .down(down),
`endif
        .load(load), .load_val(load_val),
        .q_units(ub), .q_tens(tb), .carry(cb), .load_err(eb)
    );

    function automatic logic [7:0] exp_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic bit dn();
`ifdef CONTADOR_DOWN_EN
        return down;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_carry(input int mod, input int v);
        return en && (dn() ? (v == 0) : (v == mod - 1));
    endfunction

    // Reference behaviour in plain integer arithmetic.
    function automatic void model_step(input int mod, input int rst, inout int v, inout bit e);
        int lv;
        lv = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
        if (!clear_n) begin
            v = rst; e = 0;
        end else if (load) begin
            if (load_val[7:4] <= 9 && load_val[3:0] <= 9 && lv < mod) begin
                v = lv; e = 0;
            end else begin
                e = 1;
            end
        end else begin
            e = 0;
            if (en) v = dn() ? (v + mod - 1) % mod : (v + 1) % mod;
        end
    endfunction

    task automatic tick(input bit verbose);
        @(posedge clk);
        model_step(60, 0, va, ea_m);
        model_step(24, 12, vb, eb_m);
        #1;
        if (verbose)
            $display("clr_n=%0b ld=%0b lv=%h en=%0b dn=%0b -> A=%h%h c=%0b e=%0b  B=%h%h c=%0b e=%0b",
                     clear_n, load, load_val, en, down, ta, ua, ca, ea, tb, ub, cb, eb);
    endtask

    task automatic test_reset();
        clear_n = 0; load = 1; load_val = 8'h33; en = 1;
        tick(1);
        clear_n = 1; load = 0; en = 0;
        n_checks++;
        if ({ta, ua} !== 8'h00) begin n_errors++; $display("FAIL reset_a got=%h exp=00", {ta, ua}); end
        n_checks++;
        if ({tb, ub} !== 8'h12) begin n_errors++; $display("FAIL reset_b got=%h exp=12", {tb, ub}); end
        n_checks++;
        if (ea !== 1'b0 || eb !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%0b%0b exp=00", ea, eb); end
    endtask

    task automatic test_count_wrap();
        en = 1; load = 0; down = 0;
        for (int i = 0; i < 60; i++) begin
            tick(0);
            n_checks++;
            if ({ta, ua} !== exp_bcd(va) || ca !== exp_carry(60, va)) begin
                n_errors++;
                $display("FAIL count_a step=%0d got=%h c=%0b exp=%h c=%0b", i, {ta, ua}, ca, exp_bcd(va), exp_carry(60, va));
            end
        end
        n_checks++;
        if ({ta, ua} !== 8'h00) begin n_errors++; $display("FAIL wrap59 got=%h exp=00", {ta, ua}); end
        en = 0;
        tick(1);
        n_checks++;
        if ({ta, ua} !== 8'h00 || ca !== 1'b0) begin n_errors++; $display("FAIL hold got=%h c=%0b exp=00 c=0", {ta, ua}, ca); end
    endtask

    task automatic test_load_24();
        load = 1; load_val = 8'h22; en = 1;
        tick(1);
        load = 0;
        n_checks++;
        if ({tb, ub} !== 8'h22 || eb !== 1'b0) begin n_errors++; $display("FAIL load22 got=%h e=%0b exp=22 e=0", {tb, ub}, eb); end
        tick(1);
        n_checks++;
        if ({tb, ub} !== 8'h23 || cb !== 1'b1) begin n_errors++; $display("FAIL b23 got=%h c=%0b exp=23 c=1", {tb, ub}, cb); end
        tick(1);
        n_checks++;
        if ({tb, ub} !== 8'h00 || eb !== 1'b0 || cb !== 1'b0) begin
            n_errors++; $display("FAIL wrap23 got=%h c=%0b e=%0b exp=00 c=0 e=0", {tb, ub}, cb, eb);
        end
        en = 0;
    endtask

    task automatic test_load_reject();
        load = 1; load_val = 8'h17; en = 0;
        tick(1);
        load_val = 8'h7A;
        tick(1);
        n_checks++;
        if ({ta, ua} !== 8'h17 || ea !== 1'b1 || {tb, ub} !== 8'h17 || eb !== 1'b1) begin
            n_errors++; $display("FAIL rej_nibble got A=%h e=%0b B=%h e=%0b exp 17 e=1", {ta, ua}, ea, {tb, ub}, eb);
        end
        load = 0;
        tick(1);
        n_checks++;
        if (ea !== 1'b0 || eb !== 1'b0) begin n_errors++; $display("FAIL err_clear got=%0b%0b exp=00", ea, eb); end
        load = 1; load_val = 8'h60; en = 1;
        tick(1);
        n_checks++;
        if ({ta, ua} !== 8'h17 || ea !== 1'b1 || {tb, ub} !== 8'h17 || eb !== 1'b1) begin
            n_errors++; $display("FAIL rej_mod got A=%h e=%0b B=%h e=%0b exp 17 e=1", {ta, ua}, ea, {tb, ub}, eb);
        end
        load = 0; en = 0;
    endtask

    task automatic test_load_en();
        load = 1; load_val = 8'h45; en = 1;
        tick(1);
        n_checks++;
        if ({ta, ua} !== 8'h45 || {tb, ub} !== exp_bcd(vb) || eb !== 1'b1) begin
            n_errors++; $display("FAIL load_en got A=%h B=%h eb=%0b exp A=45 B=%h eb=1", {ta, ua}, {tb, ub}, eb, exp_bcd(vb));
        end
        load = 0;
        tick(1);
        n_checks++;
        if ({ta, ua} !== 8'h46) begin n_errors++; $display("FAIL after_load got=%h exp=46", {ta, ua}); end
        en = 0;
    endtask

    task automatic test_clear_priority();
        load = 1; load_val = 8'h33; en = 0;
        tick(1);
        clear_n = 0; load = 1; load_val = 8'h45; en = 1;
        tick(1);
        clear_n = 1; load = 0; en = 0;
        n_checks++;
        if ({ta, ua} !== 8'h00 || ea !== 1'b0 || {tb, ub} !== 8'h12 || eb !== 1'b0) begin
            n_errors++; $display("FAIL clr_prio got A=%h e=%0b B=%h e=%0b exp A=00 B=12 e=0", {ta, ua}, ea, {tb, ub}, eb);
        end
    endtask

`ifdef CONTADOR_DOWN_EN
    task automatic test_down();
        load = 1; load_val = 8'h01; en = 1; down = 1;
        tick(1);
        load = 0;
        n_checks++;
        if ({ta, ua} !== 8'h01 || ca !== 1'b0) begin n_errors++; $display("FAIL dn01 got=%h c=%0b exp=01 c=0", {ta, ua}, ca); end
        tick(1);
        n_checks++;
        if ({ta, ua} !== 8'h00 || ca !== 1'b1) begin n_errors++; $display("FAIL dn00 got=%h c=%0b exp=00 c=1", {ta, ua}, ca); end
        tick(1);
        n_checks++;
        if ({ta, ua} !== 8'h59 || {tb, ub} !== exp_bcd(vb)) begin n_errors++; $display("FAIL dn59 got=%h exp=59", {ta, ua}); end
        tick(1);
        n_checks++;
        if ({ta, ua} !== 8'h58) begin n_errors++; $display("FAIL dn58 got=%h exp=58", {ta, ua}); end
        en = 0; down = 0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            clear_n = ($urandom_range(0, 99) >= 3);
            en      = ($urandom_range(0, 99) < 75);
            load    = ($urandom_range(0, 99) < 10);
            load_val = ($urandom_range(0, 1) == 1) ? exp_bcd(int'($urandom_range(0, 99))) : 8'($urandom);
`ifdef CONTADOR_DOWN_EN
            down    = $urandom_range(0, 1) == 1;
`endif
            tick(0);
            n_checks++;
            if ({ta, ua} !== exp_bcd(va) || ca !== exp_carry(60, va) || ea !== ea_m) begin
                n_errors++;
                $display("FAIL rand_a i=%0d got=%h c=%0b e=%0b exp=%h c=%0b e=%0b", i, {ta, ua}, ca, ea, exp_bcd(va), exp_carry(60, va), ea_m);
            end
            n_checks++;
            if ({tb, ub} !== exp_bcd(vb) || cb !== exp_carry(24, vb) || eb !== eb_m) begin
                n_errors++;
                $display("FAIL rand_b i=%0d got=%h c=%0b e=%0b exp=%h c=%0b e=%0b", i, {tb, ub}, cb, eb, exp_bcd(vb), exp_carry(24, vb), eb_m);
            end
        end
        clear_n = 1; en = 0; load = 0; down = 0;
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_load_24();
        test_load_reject();
        test_load_en();
        test_clear_priority();
`ifdef CONTADOR_DOWN_EN
        test_down();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
